// File: rtl/th_mn_array_if.sv
// Threshold-gate array bus: evaluate enable, channel inputs, gate outputs and wave status.
interface th_mn_array_if #(
  parameter int unsigned CH     = 4,
  parameter int unsigned IN_NUM = 4
);
  logic                 en;
  logic [CH*IN_NUM-1:0] in;
  logic [CH-1:0]        out;
  logic                 wave_done;
  logic [15:0]          wave_cnt;
  logic                 err;

  modport master (
    output en, in,
    input  out, wave_done, wave_cnt, err
  );

  modport slave (
    input  en, in,
    output out, wave_done, wave_cnt, err
  );
endinterface

// File: rtl/th_mn_array.sv
// Array of CH weighted threshold gates with a wave-tracking FSM.
// ENC "FP": four-phase return-to-null with hysteresis; "TP": two-phase transition gates.
// Define TH_MN_ARRAY_DBG_EN to expose dbg_en/dbg_in/dbg_out/dbg_state copies of internal values.
module th_mn_array #(
  parameter              ENC     = "FP",
  parameter int unsigned CH      = 4,
  parameter int unsigned IN_NUM  = 4,
  parameter int unsigned THRESH  = 2,
  parameter int unsigned WEIGHT0 = 1,
  parameter bit          INIT    = 1'b0
) (
  input logic          clk,
  input logic          rst,
  th_mn_array_if.slave bus
`ifdef TH_MN_ARRAY_DBG_EN
  ,
  output logic                 dbg_en,
  output logic [CH*IN_NUM-1:0] dbg_in,
  output logic [CH-1:0]        dbg_out,
  output logic [1:0]           dbg_state
`endif
);

  localparam bit          IsTp   = (ENC == "TP");
  localparam int unsigned MaxSum = WEIGHT0 + IN_NUM - 1;
  localparam int unsigned SumW   = $clog2(MaxSum + 1) + 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StFull  = 2'd2,
    StDrain = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CH-1:0] out_q, out_d;
  logic [CH-1:0] snap_q, snap_d;
  logic [CH-1:0] fire;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   cnt_q;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [IN_NUM-1:0] ch_in;
    logic [IN_NUM-1:0] ev;
    logic [SumW-1:0]   sum;

    assign ch_in = bus.in[c*IN_NUM +: IN_NUM];
    // Two-phase gates count inputs that currently differ from the output level.
    assign ev    = IsTp ? (ch_in ^ {IN_NUM{out_q[c]}}) : ch_in;

    // Weighted sum: input 0 carries WEIGHT0, every other input weight 1.
    always_comb begin
      sum = ev[0] ? SumW'(WEIGHT0) : '0;
      for (int i = 1; i < IN_NUM; i++) begin
        sum = sum + SumW'(ev[i]);
      end
    end

    assign fire[c]  = (sum >= SumW'(THRESH));
    // FP: set on threshold, clear only on full null, otherwise hold. TP: toggle on threshold.
    assign out_d[c] = IsTp ? (out_q[c] ^ fire[c]) :
                      fire[c] ? 1'b1 :
                      (ch_in == '0) ? 1'b0 : out_q[c];
  end

  logic          all0, all1;
  logic [CH-1:0] diff, back;

  assign all0 = (out_d == '0);
  assign all1 = &out_d;
  assign diff = out_d ^ snap_q;
  // Bits that toggled this edge and landed back on their snapshot level.
  assign back = (out_q ^ out_d) & ~diff;

  // Wave FSM next state, completion pulse and protocol-violation detection.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    done_d  = 1'b0;
    err_d   = err_q;
    if (IsTp) begin
      if ((state_q == StFill) && (|back)) begin
        err_d = 1'b1;
      end
      if (&diff) begin
        snap_d  = out_d;
        state_d = StIdle;
        done_d  = 1'b1;
      end else if (|diff) begin
        state_d = StFill;
      end else begin
        state_d = StIdle;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (all1) begin
            state_d = StFull;
          end else if (!all0) begin
            state_d = StFill;
          end
        end
        StFill: begin
          if (|(out_q & ~out_d)) begin
            err_d = 1'b1;
          end
          if (all1) begin
            state_d = StFull;
          end else if (all0) begin
            // Aborted fill: back to idle without counting a wave.
            state_d = StIdle;
          end
        end
        StFull: begin
          if (all0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (!all1) begin
            state_d = StDrain;
          end
        end
        StDrain: begin
          if (|(~out_q & out_d)) begin
            err_d = 1'b1;
          end
          if (all0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (all1) begin
            state_d = StFull;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers; en low freezes everything and only lets the done pulse drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= {CH{INIT}};
      snap_q  <= {CH{INIT}};
      state_q <= StIdle;
      done_q  <= 1'b0;
      cnt_q   <= 16'h0000;
      err_q   <= 1'b0;
    end else if (bus.en) begin
      out_q   <= out_d;
      snap_q  <= snap_d;
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (done_d) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign bus.out       = out_q;
  assign bus.wave_done = done_q;
  assign bus.wave_cnt  = cnt_q;
  assign bus.err       = err_q;

`ifdef TH_MN_ARRAY_DBG_EN
  assign dbg_en    = bus.en;
  assign dbg_in    = bus.in;
  assign dbg_out   = out_q;
  assign dbg_state = state_q;
`endif

endmodule

// File: tb/tb_th_mn_array.sv
// Directed bench for th_mn_array: five configurations sharing one clock and reset.
module tb_th_mn_array;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  th_mn_array_if #(.CH(1), .IN_NUM(4)) if_a ();
  th_mn_array_if #(.CH(1), .IN_NUM(4)) if_b ();
  th_mn_array_if #(.CH(2), .IN_NUM(4)) if_c ();
  th_mn_array_if #(.CH(2), .IN_NUM(4)) if_d ();
  th_mn_array_if #(.CH(1), .IN_NUM(4)) if_e ();

`ifdef TH_MN_ARRAY_DBG_EN
  logic       a_den, b_den, c_den, d_den, e_den;
  logic [3:0] a_din, b_din, e_din;
  logic [7:0] c_din, d_din;
  logic       a_dout, b_dout, e_dout;
  logic [1:0] c_dout, d_dout;
  logic [1:0] a_dst, b_dst, c_dst, d_dst, e_dst;
`endif

  th_mn_array #(.ENC("FP"), .CH(1), .IN_NUM(4), .THRESH(2), .WEIGHT0(1), .INIT(1'b0)) u_a (
    .clk(clk), .rst(rst), .bus(if_a)
`ifdef TH_MN_ARRAY_DBG_EN
    , .dbg_en(a_den), .dbg_in(a_din), .dbg_out(a_dout), .dbg_state(a_dst)
`endif
  );

  th_mn_array #(.ENC("FP"), .CH(1), .IN_NUM(4), .THRESH(2), .WEIGHT0(2), .INIT(1'b0)) u_b (
    .clk(clk), .rst(rst), .bus(if_b)
`ifdef TH_MN_ARRAY_DBG_EN
    , .dbg_en(b_den), .dbg_in(b_din), .dbg_out(b_dout), .dbg_state(b_dst)
`endif
  );

  th_mn_array #(.ENC("TP"), .CH(2), .IN_NUM(4), .THRESH(2), .WEIGHT0(1), .INIT(1'b0)) u_c (
    .clk(clk), .rst(rst), .bus(if_c)
`ifdef TH_MN_ARRAY_DBG_EN
    , .dbg_en(c_den), .dbg_in(c_din), .dbg_out(c_dout), .dbg_state(c_dst)
`endif
  );

  th_mn_array #(.ENC("FP"), .CH(2), .IN_NUM(4), .THRESH(2), .WEIGHT0(1), .INIT(1'b0)) u_d (
    .clk(clk), .rst(rst), .bus(if_d)
`ifdef TH_MN_ARRAY_DBG_EN
    , .dbg_en(d_den), .dbg_in(d_din), .dbg_out(d_dout), .dbg_state(d_dst)
`endif
  );

  th_mn_array #(.ENC("TP"), .CH(1), .IN_NUM(4), .THRESH(2), .WEIGHT0(1), .INIT(1'b0)) u_e (
    .clk(clk), .rst(rst), .bus(if_e)
`ifdef TH_MN_ARRAY_DBG_EN
    , .dbg_en(e_den), .dbg_in(e_din), .dbg_out(e_dout), .dbg_state(e_dst)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_a.en = 1'b1; if_a.in = '0;
    if_b.en = 1'b1; if_b.in = '0;
    if_c.en = 1'b1; if_c.in = '0;
    if_d.en = 1'b1; if_d.in = '0;
    if_e.en = 1'b1; if_e.in = '0;
    #2;
    check("rst_a_out", 32'(if_a.out), 32'h0);
    check("rst_a_cnt", 32'(if_a.wave_cnt), 32'h0);
    check("rst_a_err", 32'(if_a.err), 32'h0);
    check("rst_a_done", 32'(if_a.wave_done), 32'h0);
    check("rst_c_out", 32'(if_c.out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // FP single channel, threshold 2, with hysteresis
    if_a.in = 4'b0001; tick();
    check("a_one_in", 32'(if_a.out), 32'h0);
    if_a.in = 4'b0011; tick();
    check("a_two_in", 32'(if_a.out), 32'h1);
    if_a.in = 4'b0001; tick();
    check("a_hold", 32'(if_a.out), 32'h1);
    check("a_hold_done", 32'(if_a.wave_done), 32'h0);
    if_a.in = 4'b0000; tick();
    check("a_null_out", 32'(if_a.out), 32'h0);
    check("a_done", 32'(if_a.wave_done), 32'h1);
    check("a_cnt1", 32'(if_a.wave_cnt), 32'h1);
    tick();
    check("a_done_drop", 32'(if_a.wave_done), 32'h0);

    // Enable low freezes the gate while inputs move
    if_a.en = 1'b0; if_a.in = 4'b1111; tick();
    check("a_frz_out", 32'(if_a.out), 32'h0);
    tick();
    check("a_frz_out2", 32'(if_a.out), 32'h0);
    check("a_frz_cnt", 32'(if_a.wave_cnt), 32'h1);
    if_a.en = 1'b1; tick();
    check("a_unfrz_out", 32'(if_a.out), 32'h1);
    if_a.in = 4'b0000; tick();
    check("a_cnt2", 32'(if_a.wave_cnt), 32'h2);

    // Weighted input 0 reaches threshold alone; another single input does not
    if_b.in = 4'b0001; tick();
    check("b_w0_fires", 32'(if_b.out), 32'h1);
    if_b.in = 4'b0000; tick();
    check("b_null", 32'(if_b.out), 32'h0);
    if_b.in = 4'b0010; tick();
    check("b_w1_no_fire", 32'(if_b.out), 32'h0);

    // TP two channels: two waves, then an illegal toggle-back
    if_c.in = 8'h33; tick();
    check("c_w1_out", 32'(if_c.out), 32'h3);
    check("c_w1_done", 32'(if_c.wave_done), 32'h1);
    check("c_w1_cnt", 32'(if_c.wave_cnt), 32'h1);
    if_c.in = 8'h00; tick();
    check("c_w2_out", 32'(if_c.out), 32'h0);
    check("c_w2_cnt", 32'(if_c.wave_cnt), 32'h2);
    check("c_w2_err", 32'(if_c.err), 32'h0);
    tick();
    check("c_w2_done_drop", 32'(if_c.wave_done), 32'h0);
    if_c.in = 8'h03; tick();
    check("c_part_out", 32'(if_c.out), 32'h1);
    check("c_part_done", 32'(if_c.wave_done), 32'h0);
    if_c.in = 8'h00; tick();
    check("c_back_out", 32'(if_c.out), 32'h0);
    check("c_back_err", 32'(if_c.err), 32'h1);
    check("c_back_cnt", 32'(if_c.wave_cnt), 32'h2);

    // FP two channels: channel 0 returns to null during fill
    if_d.in = 8'h03; tick();
    check("d_fill_out", 32'(if_d.out), 32'h1);
    check("d_fill_err", 32'(if_d.err), 32'h0);
    if_d.in = 8'h00; tick();
    check("d_abort_out", 32'(if_d.out), 32'h0);
    check("d_abort_err", 32'(if_d.err), 32'h1);
    check("d_abort_done", 32'(if_d.wave_done), 32'h0);
    tick(); tick();
    check("d_err_sticky", 32'(if_d.err), 32'h1);

    // TP single channel completes a wave every edge while inputs sit at 0011
    if_e.in = 4'b0011;
    repeat (65535) tick();
    check("e_cnt_max", 32'(if_e.wave_cnt), 32'hFFFF);
    check("e_out_odd", 32'(if_e.out), 32'h1);
    tick();
    check("e_cnt_wrap", 32'(if_e.wave_cnt), 32'h0);
    check("e_wrap_done", 32'(if_e.wave_done), 32'h1);
    if_e.in = 4'b0000; tick();
    check("e_quiet_done", 32'(if_e.wave_done), 32'h0);
    check("e_quiet_cnt", 32'(if_e.wave_cnt), 32'h0);

    // Reset in the middle of a fill
    if_d.in = 8'h03; tick();
    check("d_refill_out", 32'(if_d.out), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("d_rst_out", 32'(if_d.out), 32'h0);
    check("d_rst_err", 32'(if_d.err), 32'h0);
    check("d_rst_done", 32'(if_d.wave_done), 32'h0);
    check("a_rst_cnt", 32'(if_a.wave_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("d_rel_out", 32'(if_d.out), 32'h1);
    check("d_rel_done", 32'(if_d.wave_done), 32'h0);
    check("d_rel_err", 32'(if_d.err), 32'h0);
    check("d_rel_cnt", 32'(if_d.wave_cnt), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
